// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the pipelined MIPS core: owns HI/LO, models
// fixed MULT/DIV latency with a busy counter and raises the D-stage stall.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [63:0]       pend_q, pend_d;
  logic              div0_q, div0_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              accept_s;
  logic [63:0]       smul_s, umul_s;
  logic [31:0]       mag_a_s, mag_b_s, div_b_s;
  logic [31:0]       sq_mag_s, sr_mag_s, sq_s, sr_s, uq_s, ur_s;
  logic [63:0]       result_s;

  assign accept_s = start & (state_q == S_IDLE);

  // Result is computed from the operands present on the start edge and parked in pend_q.
  always_comb begin
    smul_s   = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    umul_s   = {32'd0, op_a} * {32'd0, op_b};
    // A zero divisor is replaced so the divider stays defined; its result is discarded.
    div_b_s  = (op_b == 32'd0) ? 32'd1 : op_b;
    mag_a_s  = op_a[31] ? (32'd0 - op_a) : op_a;
    mag_b_s  = op_b[31] ? (32'd0 - op_b) : div_b_s;
    sq_mag_s = mag_a_s / mag_b_s;
    sr_mag_s = mag_a_s % mag_b_s;
    sq_s     = (op_a[31] ^ op_b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    sr_s     = op_a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
    uq_s     = op_a / div_b_s;
    ur_s     = op_a % div_b_s;
    case (md_op)
      OP_MULT:  result_s = smul_s;
      OP_MULTU: result_s = umul_s;
      OP_DIV:   result_s = {sr_s, sq_s};
      OP_DIVU:  result_s = {ur_s, uq_s};
      default:  result_s = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= 64'd0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (md_op <= OP_DIVU)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    pend_d = pend_q;
    div0_d = div0_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              cnt_d  = MULT_LOAD;
              busy_d = 1'b1;
              pend_d = result_s;
              div0_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              cnt_d  = DIV_LOAD;
              busy_d = 1'b1;
              pend_d = result_s;
              div0_d = (op_b == 32'd0);
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: begin
              cnt_d  = cnt_q;
              busy_d = busy_q;
            end
          endcase
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          busy_d = 1'b0;
          if (!div0_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = md_use & (busy_q | (start & (md_op <= OP_DIVU)));

endmodule
